iic_slave_regbank: RTL

Register bank sitting directly downstream of `iic_multi_slave_clk`. It consumes the slave's unit-wide write strobes and serves its read requests with one-cycle latency. Local logic gets a second port for status/read-only registers and a FIFO of change events for every register written over I2C. It turns the pass-through slave into a usable, software-visible register map.

---
 rtl/iic_regbank_pkg.sv | 22 ++
 rtl/iic_regbank_chg_fifo.sv | 54 +++++
 rtl/iic_slave_regbank.sv | 110 +++++++++++
 3 files changed

// File: rtl/iic_regbank_pkg.sv
// iic_regbank_pkg: shared widths, change-event entry type and clog2 helper
// for the I2C slave register bank.
package iic_regbank_pkg;

    localparam int C_ADDR_BYTES = 2;
    localparam int C_DATA_BYTES = 2;
    localparam int C_AW         = C_ADDR_BYTES * 8;
    localparam int C_DW         = C_DATA_BYTES * 8;

    typedef struct packed {
        logic [C_AW-1:0] addr;
        logic [C_DW-1:0] data;
    } chg_entry_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/iic_regbank_chg_fifo.sv
// iic_regbank_chg_fifo: first-word-fall-through FIFO of I2C change events with
// sticky overflow; built only when IIC_REGBANK_CHG_FIFO_EN is defined.
`ifdef IIC_REGBANK_CHG_FIFO_EN
module iic_regbank_chg_fifo
    import iic_regbank_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  chg_entry_t i_entry,
    input  logic       i_pop,
    input  logic       i_ovf_clr,
    output logic       o_valid,
    output chg_entry_t o_entry,
    output logic       o_ovf
);
    localparam int PW = clog2(C_FIFO_DEPTH);

    chg_entry_t    r_mem [C_FIFO_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;
    logic          r_ovf;
    logic          w_full, w_pop, w_wr;

    assign w_full  = r_cnt == (PW+1)'(C_FIFO_DEPTH);
    assign o_valid = r_cnt != '0;
    assign w_pop   = i_pop && o_valid;
    // a pop frees the slot in the same cycle, so a push into a full FIFO is kept
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_entry = o_valid ? r_mem[r_rp] : '0;
    assign o_ovf   = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
            if (i_push && w_full && !w_pop) r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp] <= i_entry;
    end
endmodule
`endif

// File: rtl/iic_slave_regbank.sv
// iic_slave_regbank: register map behind iic_multi_slave_clk with a local port,
// RO region, error pulses and an optional change FIFO (IIC_REGBANK_CHG_FIFO_EN).
module iic_slave_regbank
    import iic_regbank_pkg::*;
#(
    parameter int C_RAM_ADDR_BYTE_NUM = C_ADDR_BYTES,
    parameter int C_RAM_DATA_BYTE_NUM = C_DATA_BYTES,
    parameter int C_DEPTH             = 64,
    parameter int C_RO_BASE           = 48,
    parameter int C_FIFO_DEPTH        = 8
) (
    input  logic                             SYS_CLK_I,
    input  logic                             SYS_RST_I,
    input  logic                             WR_EN_I,
    input  logic [C_RAM_ADDR_BYTE_NUM*8-1:0] WR_ADDR_I,
    input  logic [C_RAM_DATA_BYTE_NUM*8-1:0] WR_DATA_I,
    input  logic                             RD_EN_I,
    input  logic [C_RAM_ADDR_BYTE_NUM*8-1:0] RD_ADDR_I,
    output logic [C_RAM_DATA_BYTE_NUM*8-1:0] RD_DATA_O,
    input  logic                             USR_WR_EN_I,
    input  logic [C_RAM_ADDR_BYTE_NUM*8-1:0] USR_WR_ADDR_I,
    input  logic [C_RAM_DATA_BYTE_NUM*8-1:0] USR_WR_DATA_I,
    input  logic [C_RAM_ADDR_BYTE_NUM*8-1:0] USR_RD_ADDR_I,
    output logic [C_RAM_DATA_BYTE_NUM*8-1:0] USR_RD_DATA_O,
    output logic                             CHG_VALID_O,
    output logic [C_RAM_ADDR_BYTE_NUM*8-1:0] CHG_ADDR_O,
    output logic [C_RAM_DATA_BYTE_NUM*8-1:0] CHG_DATA_O,
    input  logic                             CHG_READY_I,
    output logic                             CHG_OVF_O,
    input  logic                             CHG_OVF_CLR_I,
    output logic                             ERR_RO_O,
    output logic                             ERR_RANGE_O
);
    localparam int DW = C_RAM_DATA_BYTE_NUM * 8;
    localparam int IW = clog2(C_DEPTH);

    logic [DW-1:0] r_mem [C_DEPTH];
    logic [DW-1:0] r_rd_data, r_usr_rd_data;
    logic          r_err_ro, r_err_range;

    logic          w_wr_in, w_rd_in, w_usr_wr_in, w_usr_rd_in;
    logic          w_usr_ok, w_collide, w_i2c_ok, w_ro_hit;
    logic [IW-1:0] w_wa, w_ra, w_ua, w_ura;

    assign w_wr_in     = 32'(WR_ADDR_I) < C_DEPTH;
    assign w_rd_in     = 32'(RD_ADDR_I) < C_DEPTH;
    assign w_usr_wr_in = 32'(USR_WR_ADDR_I) < C_DEPTH;
    assign w_usr_rd_in = 32'(USR_RD_ADDR_I) < C_DEPTH;
    assign w_wa        = WR_ADDR_I[IW-1:0];
    assign w_ra        = RD_ADDR_I[IW-1:0];
    assign w_ua        = USR_WR_ADDR_I[IW-1:0];
    assign w_ura       = USR_RD_ADDR_I[IW-1:0];

    assign w_ro_hit  = w_wr_in && 32'(WR_ADDR_I) >= C_RO_BASE;
    assign w_usr_ok  = USR_WR_EN_I && w_usr_wr_in;
    // a same-address local write wins; the I2C write is dropped entirely
    assign w_collide = w_usr_ok && WR_EN_I && USR_WR_ADDR_I == WR_ADDR_I;
    assign w_i2c_ok  = WR_EN_I && w_wr_in && !w_ro_hit && !w_collide;

    always_ff @(posedge SYS_CLK_I or negedge SYS_RST_I) begin
        if (!SYS_RST_I) begin
            for (int i = 0; i < C_DEPTH; i++) r_mem[i] <= '0;
            r_rd_data     <= '0;
            r_usr_rd_data <= '0;
            r_err_ro      <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_i2c_ok) r_mem[w_wa] <= WR_DATA_I;
            if (w_usr_ok) r_mem[w_ua] <= USR_WR_DATA_I;
            if (RD_EN_I) r_rd_data <= w_rd_in ? r_mem[w_ra] : '0;
            r_usr_rd_data <= w_usr_rd_in ? r_mem[w_ura] : '0;
            r_err_ro      <= WR_EN_I && w_ro_hit;
            r_err_range   <= (WR_EN_I && !w_wr_in) || (RD_EN_I && !w_rd_in);
        end
    end

    assign RD_DATA_O     = r_rd_data;
    assign USR_RD_DATA_O = r_usr_rd_data;
    assign ERR_RO_O      = r_err_ro;
    assign ERR_RANGE_O   = r_err_range;

`ifdef IIC_REGBANK_CHG_FIFO_EN
    chg_entry_t w_head;

    iic_regbank_chg_fifo #(
        .C_FIFO_DEPTH(C_FIFO_DEPTH)
    ) u_chg_fifo (
        .i_clk    (SYS_CLK_I),
        .i_rst_n  (SYS_RST_I),
        .i_push   (w_i2c_ok),
        .i_entry  ('{addr: WR_ADDR_I, data: WR_DATA_I}),
        .i_pop    (CHG_READY_I),
        .i_ovf_clr(CHG_OVF_CLR_I),
        .o_valid  (CHG_VALID_O),
        .o_entry  (w_head),
        .o_ovf    (CHG_OVF_O)
    );

    assign CHG_ADDR_O = w_head.addr;
    assign CHG_DATA_O = w_head.data;
`else
    logic w_unused;

    assign w_unused    = CHG_READY_I ^ CHG_OVF_CLR_I;
    assign CHG_VALID_O = 1'b0;
    assign CHG_ADDR_O  = '0;
    assign CHG_DATA_O  = '0;
    assign CHG_OVF_O   = 1'b0;
`endif
endmodule
